// File: rtl/data_mem_sb_pkg.sv
// Shared constants for the data memory with store buffer: default geometry and
// the legality check for a byte address against the word array size.
package data_mem_sb_pkg;

    localparam int unsigned DEPTH_WORDS_DEF = 256;
    localparam int unsigned SB_DEPTH_DEF    = 2;
    localparam int unsigned IDX_W_DEF       = $clog2(DEPTH_WORDS_DEF);

    // Word-aligned and inside the array.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(depth));
    endfunction

endpackage

// File: rtl/data_mem_store_buffer.sv
// In-order store buffer: circular FIFO of {word index, data} with a parallel
// lookup port that returns the youngest entry matching a given index.
module data_mem_store_buffer
    import data_mem_sb_pkg::*;
#(
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter int unsigned SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic [IDX_W-1:0]            push_idx_i,
    input  logic [31:0]                 push_data_i,
    input  logic                        pop_i,
    output logic [IDX_W-1:0]            pop_idx_o,
    output logic [31:0]                 pop_data_o,
    input  logic [IDX_W-1:0]            look_idx_i,
    output logic                        look_hit_o,
    output logic [31:0]                 look_data_o,
    output logic [$clog2(SB_DEPTH):0]   count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] idx_q  [SB_DEPTH];
    logic [31:0]      data_q [SB_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] slot;

    assign full_o     = (count_q == CNT_W'(SB_DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_idx_o  = idx_q[rd_ptr_q];
    assign pop_data_o = data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
        else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        look_hit_o  = 1'b0;
        look_data_o = '0;
        slot        = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            slot = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (idx_q[slot] == look_idx_i)) begin
                look_hit_o  = 1'b1;
                look_data_o = data_q[slot];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            idx_q[wr_ptr_q]  <= push_idx_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/data_mem_sb.sv
// Data memory for the MEM stage: stores are queued in a store buffer and drained
// into the word array on cycles without a load; loads forward from the buffer.
module data_mem_sb
    import data_mem_sb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned SB_DEPTH    = SB_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dmem_we,
    input  logic                        dmem_re,
    input  logic [31:0]                 dmem_addr,
    input  logic [31:0]                 dmem_wdata,
    output logic [31:0]                 dmem_rdata,
    output logic                        dmem_fault,
    output logic [$clog2(SB_DEPTH):0]   sb_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic             legal;
    logic [IDX_W-1:0] idx;
    logic             push, pop;
    logic             sb_full, sb_empty;
    logic [IDX_W-1:0] pop_idx;
    logic [31:0]      pop_data;
    logic             look_hit;
    logic [31:0]      look_data;
    logic             fault_q, fault_d;

    assign legal = addr_legal(dmem_addr, DEPTH_WORDS);
    assign idx   = dmem_addr[IDX_W+1:2];

    data_mem_store_buffer #(
        .IDX_W    (IDX_W),
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_idx_i  (idx),
        .push_data_i (dmem_wdata),
        .pop_i       (pop),
        .pop_idx_o   (pop_idx),
        .pop_data_o  (pop_data),
        .look_idx_i  (idx),
        .look_hit_o  (look_hit),
        .look_data_o (look_data),
        .count_o     (sb_count),
        .full_o      (sb_full),
        .empty_o     (sb_empty)
    );

    // A load blocks the drain, except when a store must enter a full buffer.
    always_comb begin
        push    = !rst && dmem_we && legal;
        pop     = !rst && !sb_empty && (!dmem_re || (sb_full && push));
        fault_d = !rst && (dmem_we || dmem_re) && !legal;
    end

    always_comb begin
        dmem_rdata = '0;
        if (legal) begin
            if (look_hit && !rst) dmem_rdata = look_data;
            else                  dmem_rdata = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    always_ff @(posedge clk) begin
        if (pop) mem_q[pop_idx] <= pop_data;
    end

    assign dmem_fault = fault_q;

endmodule
